serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 10 +
 rtl/full_adder.sv | 30 +++
 rtl/half_adder.sv | 12 +
 rtl/serial_adder.sv | 115 +++++++++++
 tb/tb_serial_adder.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder built from two half adders and an OR on the carries.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .a (s0),
    .b (cin),
    .s (s),
    .c (c1)
  );

  assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder: sum and carry of two inputs.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB-first, one bit per clock,
// with a start/busy/done handshake and carry/signed-overflow flags.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] opa_reg, opa_next;
  logic [WIDTH-1:0] opb_reg, opb_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             cff_reg, cff_next;
  logic             carry_reg, carry_next;
  logic             ovf_reg, ovf_next;

  logic fa_s;
  logic fa_cout;

  full_adder u_fa (
    .a    (opa_reg[0]),
    .b    (opb_reg[0]),
    .cin  (cff_reg),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_next = state_reg;
    opa_next   = opa_reg;
    opb_next   = opb_reg;
    sum_next   = sum_reg;
    cnt_next   = cnt_reg;
    cff_next   = cff_reg;
    carry_next = carry_reg;
    ovf_next   = ovf_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: the +1 enters through the carry flop.
          opa_next   = a;
          opb_next   = sub ? ~b : b;
          cff_next   = sub;
          cnt_next   = '0;
          sum_next   = '0;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end

      RUN: begin
        sum_next = {fa_s, sum_reg[WIDTH-1:1]};
        opa_next = {1'b0, opa_reg[WIDTH-1:1]};
        opb_next = {1'b0, opb_reg[WIDTH-1:1]};
        cff_next = fa_cout;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST) begin
          // cff_reg here is the carry into the MSB.
          carry_next = fa_cout;
          ovf_next   = cff_reg ^ fa_cout;
          state_next = DONE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      opa_reg   <= '0;
      opb_reg   <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      cff_reg   <= 1'b0;
      carry_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      opa_reg   <= opa_next;
      opb_reg   <= opb_next;
      sum_reg   <= sum_next;
      cnt_reg   <= cnt_next;
      cff_reg   <= cff_next;
      carry_reg <= carry_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign busy     = (state_reg == RUN);
  assign done     = (state_reg == DONE);
  assign sum      = sum_reg;
  assign carry    = carry_reg;
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=4 and WIDTH=8: vector table,
// hand-written handshake sequences, and a scoreboard fed at every accepted start.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start4 = 1'b0, sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, carry4, ovf4;
  logic [3:0] sum4;

  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, carry8, ovf8;
  logic [7:0] sum8;

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .carry(carry4), .overflow(ovf4)
  );

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .overflow(ovf8)
  );

  int tests = 0;
  int fails = 0;
  int acc4 = 0, acc8 = 0, dn4 = 0, dn8 = 0;

  typedef struct {
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sub;
    logic [3:0] sum;
    logic       carry;
    logic       ovf;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: sum/carry from the unsigned rule, overflow from operand/result signs.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic s);
    exp_t r;
    longint unsigned mask, aa, bv, bb, full;
    logic sa, sb, sr;
    mask = (64'd1 << w) - 64'd1;
    aa   = longint'(a) & mask;
    bv   = longint'(b);
    bb   = (s ? ~bv : bv) & mask;
    full = aa + bb + longint'(s);
    r.sum   = 32'(full & mask);
    r.carry = full[w];
    sa = aa[w-1];
    sb = bv[w-1];
    sr = r.sum[w-1];
    r.ovf = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return r;
  endfunction

  task automatic push4(input logic [3:0] a, input logic [3:0] b, input logic s);
    q4.push_back(model(4, 32'(a), 32'(b), s));
    acc4++;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s);
    int n;
    @(negedge clk);
    a4 = a; b4 = b; sub4 = s; start4 = 1'b1;
    push4(a, b, s);
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (done4 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done4 !== 1'b1) begin
      tests++; fails++;
      $display("FAIL op4_timeout: got no done expected done within 40 cycles");
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int n;
    @(negedge clk);
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    q8.push_back(model(8, 32'(a), 32'(b), s));
    acc8++;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done8 !== 1'b1) begin
      tests++; fails++;
      $display("FAIL op8_timeout: got no done expected done within 40 cycles");
    end
  endtask

  // Scoreboards: every done pulse must match the oldest outstanding accepted start.
  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      dn4++;
      if (q4.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb4_unexpected_done: got done expected none");
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("sb4_sum", 32'(sum4), e.sum);
        check("sb4_carry", 32'(carry4), 32'(e.carry));
        check("sb4_ovf", 32'(ovf4), 32'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      dn8++;
      if (q8.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb8_unexpected_done: got done expected none");
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("sb8_sum", 32'(sum8), e.sum);
        check("sb8_carry", 32'(carry8), 32'(e.carry));
        check("sb8_ovf", 32'(ovf8), 32'(e.ovf));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{4'd3,  4'd5, 1'b0, 4'd8,  1'b0, 1'b1};
    tbl[1] = '{4'd15, 4'd1, 1'b0, 4'd0,  1'b1, 1'b0};
    tbl[2] = '{4'd5,  4'd3, 1'b1, 4'd2,  1'b1, 1'b0};
    tbl[3] = '{4'd3,  4'd5, 1'b1, 4'd14, 1'b0, 1'b0};
    tbl[4] = '{4'd8,  4'd1, 1'b1, 4'd7,  1'b1, 1'b1};
    tbl[5] = '{4'd7,  4'd1, 1'b0, 4'd8,  1'b0, 1'b1};
    tbl[6] = '{4'd0,  4'd0, 1'b1, 4'd0,  1'b1, 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy4", 32'(busy4), 0);
    check("rst_done4", 32'(done4), 0);
    check("rst_sum4", 32'(sum4), 0);
    check("rst_carry4", 32'(carry4), 0);
    check("rst_ovf4", 32'(ovf4), 0);
    check("rst_busy8", 32'(busy8), 0);
    check("rst_sum8", 32'(sum8), 0);
    rst = 1'b0;

    // Latency: busy for 4 cycles, done on the 5th, result held afterwards
    @(negedge clk);
    a4 = 4'd3; b4 = 4'd5; sub4 = 1'b0; start4 = 1'b1;
    push4(4'd3, 4'd5, 1'b0);
    @(negedge clk);
    start4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("lat_busy", 32'(busy4), 1);
      check("lat_nodone", 32'(done4), 0);
      @(negedge clk);
    end
    check("lat_done", 32'(done4), 1);
    check("lat_busy_in_done", 32'(busy4), 0);
    check("lat_sum", 32'(sum4), 8);
    check("lat_carry", 32'(carry4), 0);
    check("lat_ovf", 32'(ovf4), 1);
    @(negedge clk);
    check("hold_done", 32'(done4), 0);
    check("hold_sum", 32'(sum4), 8);
    $display("[TB] latency op 3+5 -> sum=%0d carry=%0d ovf=%0d", sum4, carry4, ovf4);

    // Vector table
    for (int i = 0; i < 7; i++) begin
      op4(tbl[i].a, tbl[i].b, tbl[i].sub);
      check("tbl_sum", 32'(sum4), 32'(tbl[i].sum));
      check("tbl_carry", 32'(carry4), 32'(tbl[i].carry));
      check("tbl_ovf", 32'(ovf4), 32'(tbl[i].ovf));
      $display("[TB] vec %0d: a=%0d b=%0d sub=%0d -> sum=%0d carry=%0d ovf=%0d",
               i, tbl[i].a, tbl[i].b, tbl[i].sub, sum4, carry4, ovf4);
    end

    // Start during RUN is ignored
    @(negedge clk);
    a4 = 4'd3; b4 = 4'd5; sub4 = 1'b0; start4 = 1'b1;
    push4(4'd3, 4'd5, 1'b0);
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("ign_busy", 32'(busy4), 1);
    @(negedge clk);
    check("ign_nodone_early", 32'(done4), 0);
    @(negedge clk);
    check("ign_done", 32'(done4), 1);
    check("ign_sum", 32'(sum4), 8);
    repeat (6) @(negedge clk);
    check("ign_idle", 32'(busy4), 0);
    $display("[TB] ignored-start op -> sum=%0d", sum4);

    // Back-to-back: start held through DONE
    @(negedge clk);
    a4 = 4'd3; b4 = 4'd5; sub4 = 1'b0; start4 = 1'b1;
    push4(4'd3, 4'd5, 1'b0);
    push4(4'd2, 4'd2, 1'b0);
    @(negedge clk);
    a4 = 4'd2; b4 = 4'd2;
    repeat (4) @(negedge clk);
    check("b2b_done1", 32'(done4), 1);
    check("b2b_sum1", 32'(sum4), 8);
    @(negedge clk);
    check("b2b_no_idle", 32'(busy4), 1);
    check("b2b_nodone", 32'(done4), 0);
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_nodone_early", 32'(done4), 0);
    @(negedge clk);
    check("b2b_done2", 32'(done4), 1);
    check("b2b_sum2", 32'(sum4), 4);
    $display("[TB] back-to-back second op 2+2 -> sum=%0d", sum4);

    // Reset mid-operation aborts with no done
    @(negedge clk);
    a4 = 4'd3; b4 = 4'd5; sub4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy4), 0);
    check("abort_sum", 32'(sum4), 0);
    check("abort_done", 32'(done4), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_still_idle", 32'(busy4), 0);
    op4(4'd6, 4'd7, 1'b0);
    check("post_abort_sum", 32'(sum4), 13);
    check("post_abort_carry", 32'(carry4), 0);
    check("post_abort_ovf", 32'(ovf4), 1);
    $display("[TB] post-abort op 6+7 -> sum=%0d", sum4);

    // Exhaustive WIDTH=4
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          op4(4'(x), 4'(y), 1'(s));
    $display("[TB] exhaustive width-4 sweep issued %0d ops", 512);

    // Random WIDTH=8
    for (int i = 0; i < 1000; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom));
    $display("[TB] random width-8 sweep issued %0d ops", 1000);

    repeat (3) @(negedge clk);
    check("sb4_pending", 32'(q4.size()), 0);
    check("sb8_pending", 32'(q8.size()), 0);
    check("done4_count", 32'(dn4), 32'(acc4));
    check("done8_count", 32'(dn8), 32'(acc8));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
